// File: rtl/integer_mac_pkg.sv
// rtl/integer_mac_pkg.sv - shared widths, FSM state type and parameter check for the integer MAC PE
package integer_mac_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_SHIFT  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mac_state_t;

    // The accumulator must hold a full product, and the shifted window must fit inside it.
    function automatic bit widths_ok(input int data_w, input int acc_w,
                                     input int out_w, input int shift);
        return (data_w > 0) && (out_w > 0) && (acc_w >= 2 * data_w) &&
               (shift >= 0) && (shift <= acc_w - out_w);
    endfunction

endpackage

// File: rtl/integer_mac_narrow.sv
// rtl/integer_mac_narrow.sv - arithmetic shift then saturate (INTEGER_MAC_PE_SAT_EN) or truncate
module integer_mac_narrow
    import integer_mac_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic [ACC_W-1:0] acc_in,
    output logic [OUT_W-1:0] result,
    output logic             sat
);

    // Floor rounding falls out of the arithmetic shift of a two's complement value.
    logic signed [ACC_W-1:0] shifted;
    assign shifted = $signed(acc_in) >>> SHIFT;

`ifdef INTEGER_MAC_PE_SAT_EN
    logic upper_ones;
    logic upper_zeros;
    assign upper_ones  = &shifted[ACC_W-1:OUT_W-1];
    assign upper_zeros = ~|shifted[ACC_W-1:OUT_W-1];

    // Value fits only when every bit above the output sign bit matches it; otherwise clamp.
    always_comb begin
        result = shifted[OUT_W-1:0];
        sat    = 1'b0;
        if (!(upper_ones || upper_zeros)) begin
            sat = 1'b1;
            if (shifted[ACC_W-1]) begin
                result = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                result = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end
`else
    logic unused_upper;
    assign unused_upper = ^shifted;
    assign result       = shifted[OUT_W-1:0];
    assign sat          = 1'b0;
`endif

endmodule

// File: rtl/integer_mac_pe_os.sv
// rtl/integer_mac_pe_os.sv - output-stationary integer MAC PE with drain chain; optional INTEGER_MAC_PE_SAT_EN
module integer_mac_pe_os
    import integer_mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_row,
    input  logic [DATA_W-1:0] in_col,
    input  logic              in_valid,
    input  logic              in_last,
    output logic [DATA_W-1:0] out_row,
    output logic [DATA_W-1:0] out_col,
    output logic              out_valid,
    output logic              out_last,
    input  logic              drain_load,
    input  logic              drain_shift,
    input  logic [OUT_W-1:0]  drain_in,
    input  logic              drain_in_valid,
    output logic [OUT_W-1:0]  drain_out,
    output logic              drain_out_valid,
    output logic              drain_out_sat,
    output logic              result_full,
    output logic              result_lost
);

    localparam bit WIDTHS_OK = widths_ok(DATA_W, ACC_W, OUT_W, SHIFT);
    if (!WIDTHS_OK) begin : g_width_check
        $fatal(1, "integer_mac_pe_os: need ACC_W >= 2*DATA_W and SHIFT <= ACC_W-OUT_W");
    end

    mac_state_t                 state;
    mac_state_t                 state_next;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    prod_ext;
    logic                       finalise;
    logic [OUT_W-1:0]           narrow_result;
    logic                       narrow_sat;
    logic [OUT_W-1:0]           result;
    logic                       sat_flag;

    assign product  = $signed(in_row) * $signed(in_col);
    assign prod_ext = ACC_W'(product);
    assign finalise = in_valid && in_last;

    // One-cycle pass-through of the operand stream; the PE never stalls it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_row   <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_row   <= in_row;
            out_col   <= in_col;
            out_valid <= in_valid;
            out_last  <= in_valid && in_last;
        end
    end

    // Accumulator FSM state and running sum.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            acc   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
        end
    end

    // First beat of a frame restarts the sum; last beat returns to IDLE (single-beat frames allowed).
    always_comb begin
        state_next = state;
        acc_next   = acc;
        if (in_valid) begin
            if (state == ST_IDLE) begin
                acc_next = prod_ext;
            end else begin
                acc_next = acc + prod_ext;
            end
            state_next = in_last ? ST_IDLE : ST_RUN;
        end
    end

    // The value being finalised is this cycle's sum, so narrow acc_next rather than acc.
    integer_mac_narrow #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_narrow (
        .acc_in (acc_next),
        .result (narrow_result),
        .sat    (narrow_sat)
    );

    // Holding register: a load empties it unless a new result lands in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result      <= '0;
            sat_flag    <= 1'b0;
            result_full <= 1'b0;
            result_lost <= 1'b0;
        end else begin
            if (finalise) begin
                result      <= narrow_result;
                sat_flag    <= narrow_sat;
                result_full <= 1'b1;
                if (result_full && !drain_load) begin
                    result_lost <= 1'b1;
                end
            end else if (drain_load) begin
                result_full <= 1'b0;
            end
        end
    end

    // Drain register: load from the holding register wins over shifting from upstream.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drain_out       <= '0;
            drain_out_valid <= 1'b0;
            drain_out_sat   <= 1'b0;
        end else if (drain_load) begin
            if (result_full) begin
                drain_out       <= result;
                drain_out_sat   <= sat_flag;
                drain_out_valid <= 1'b1;
            end else begin
                drain_out_valid <= 1'b0;
            end
        end else if (drain_shift) begin
            drain_out       <= drain_in;
            drain_out_valid <= drain_in_valid;
            drain_out_sat   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_integer_mac_pe_os.sv
// tb/tb_integer_mac_pe_os.sv - scoreboard bench for integer_mac_pe_os
module tb_integer_mac_pe_os;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   n_tests = 0;
    int   n_fail  = 0;

    // main PE (downstream end of the chain)
    logic [15:0] m_row, m_col, m_orow, m_ocol, m_dout;
    logic        m_valid, m_last, m_load, m_shift;
    logic        m_ovalid, m_olast, m_dvalid, m_dsat, m_full, m_lost;
    // upstream PE feeding the main drain input
    logic [15:0] u_row, u_col, u_orow, u_ocol, u_dout;
    logic        u_valid, u_last, u_load, u_shift;
    logic        u_ovalid, u_olast, u_dvalid, u_dsat, u_full, u_lost;
    // SHIFT=8 PE
    logic [15:0] s_row, s_col, s_orow, s_ocol, s_dout;
    logic        s_valid, s_last, s_load, s_shift;
    logic        s_ovalid, s_olast, s_dvalid, s_dsat, s_full, s_lost;

    integer_mac_pe_os #(.DATA_W(16), .ACC_W(40), .OUT_W(16), .SHIFT(0)) u_dut (
        .clk(clk), .rstn(rstn), .in_row(m_row), .in_col(m_col), .in_valid(m_valid), .in_last(m_last),
        .out_row(m_orow), .out_col(m_ocol), .out_valid(m_ovalid), .out_last(m_olast),
        .drain_load(m_load), .drain_shift(m_shift), .drain_in(u_dout), .drain_in_valid(u_dvalid),
        .drain_out(m_dout), .drain_out_valid(m_dvalid), .drain_out_sat(m_dsat),
        .result_full(m_full), .result_lost(m_lost));

    integer_mac_pe_os #(.DATA_W(16), .ACC_W(40), .OUT_W(16), .SHIFT(0)) u_up (
        .clk(clk), .rstn(rstn), .in_row(u_row), .in_col(u_col), .in_valid(u_valid), .in_last(u_last),
        .out_row(u_orow), .out_col(u_ocol), .out_valid(u_ovalid), .out_last(u_olast),
        .drain_load(u_load), .drain_shift(u_shift), .drain_in(16'h0000), .drain_in_valid(1'b0),
        .drain_out(u_dout), .drain_out_valid(u_dvalid), .drain_out_sat(u_dsat),
        .result_full(u_full), .result_lost(u_lost));

    integer_mac_pe_os #(.DATA_W(16), .ACC_W(40), .OUT_W(16), .SHIFT(8)) u_sh8 (
        .clk(clk), .rstn(rstn), .in_row(s_row), .in_col(s_col), .in_valid(s_valid), .in_last(s_last),
        .out_row(s_orow), .out_col(s_ocol), .out_valid(s_ovalid), .out_last(s_olast),
        .drain_load(s_load), .drain_shift(s_shift), .drain_in(16'h0000), .drain_in_valid(1'b0),
        .drain_out(s_dout), .drain_out_valid(s_dvalid), .drain_out_sat(s_dsat),
        .result_full(s_full), .result_lost(s_lost));

    // Scoreboards hold {sat, value} expected on the drain register after each load/shift.
    logic [16:0] q_m[$];
    logic [16:0] q_s[$];
    logic [16:0] e_m, e_s;
    logic        m_act, s_act;

    always @(posedge clk) begin
        m_act <= m_load | m_shift;
        s_act <= s_load | s_shift;
    end

    always @(negedge clk) begin
        if (m_act === 1'b1 && m_dvalid === 1'b1) begin
            n_tests++;
            if (q_m.size() == 0) begin
                n_fail++;
                $display("FAIL main_drain: unexpected output %0d, expected none", $signed(m_dout));
            end else begin
                e_m = q_m.pop_front();
                if ({m_dsat, m_dout} !== e_m) begin
                    n_fail++;
                    $display("FAIL main_drain: got val=%0d sat=%0b expected val=%0d sat=%0b",
                             $signed(m_dout), m_dsat, $signed(e_m[15:0]), e_m[16]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (s_act === 1'b1 && s_dvalid === 1'b1) begin
            n_tests++;
            if (q_s.size() == 0) begin
                n_fail++;
                $display("FAIL sh8_drain: unexpected output %0d, expected none", $signed(s_dout));
            end else begin
                e_s = q_s.pop_front();
                if ({s_dsat, s_dout} !== e_s) begin
                    n_fail++;
                    $display("FAIL sh8_drain: got val=%0d sat=%0b expected val=%0d sat=%0b",
                             $signed(s_dout), s_dsat, $signed(e_s[15:0]), e_s[16]);
                end
            end
        end
    end

    function automatic logic [16:0] pk(input bit sat, input int v);
        return {sat, v[15:0]};
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input int r, input int c, input bit v, input bit l);
        case (sel)
            0: begin m_row = r[15:0]; m_col = c[15:0]; m_valid = v; m_last = l; end
            1: begin u_row = r[15:0]; u_col = c[15:0]; u_valid = v; u_last = l; end
            default: begin s_row = r[15:0]; s_col = c[15:0]; s_valid = v; s_last = l; end
        endcase
    endtask

    initial begin
        rstn = 1'b0;
        drive(0, 9, 9, 1'b1, 1'b1);
        drive(1, 9, 9, 1'b1, 1'b1);
        drive(2, 9, 9, 1'b1, 1'b1);
        m_load = 1'b0; m_shift = 1'b0;
        u_load = 1'b0; u_shift = 1'b0;
        s_load = 1'b0; s_shift = 1'b0;
        repeat (3) tick();

        // reset holds every output at zero despite live inputs
        chk("rst_out_row", m_orow, 0);
        chk("rst_out_col", m_ocol, 0);
        chk("rst_out_valid", m_ovalid, 0);
        chk("rst_out_last", m_olast, 0);
        chk("rst_drain_out", m_dout, 0);
        chk("rst_drain_valid", m_dvalid, 0);
        chk("rst_drain_sat", m_dsat, 0);
        chk("rst_full", m_full, 0);
        chk("rst_lost", m_lost, 0);
        chk("rst_up_full", u_full, 0);
        chk("rst_sh8_full", s_full, 0);

        drive(0, 0, 0, 1'b0, 1'b0);
        drive(1, 0, 0, 1'b0, 1'b0);
        drive(2, 0, 0, 1'b0, 1'b0);
        rstn = 1'b1;
        tick();

        // forwarding and a three-beat frame: 12 - 30 - 14 = -32
        drive(0, 3, 4, 1'b1, 1'b0);
        tick();
        chk("fwd_row", m_orow, 3);
        chk("fwd_col", m_ocol, 4);
        chk("fwd_valid", m_ovalid, 1);
        chk("fwd_last", m_olast, 0);
        chk("fwd_full", m_full, 0);
        drive(0, -5, 6, 1'b1, 1'b0);
        tick();
        drive(0, 7, -2, 1'b1, 1'b1);
        tick();
        chk("frame_out_last", m_olast, 1);
        chk("frame_full", m_full, 1);
        drive(0, 0, 0, 1'b0, 1'b0);
        m_load = 1'b1; q_m.push_back(pk(1'b0, -32));
        tick();
        m_load = 1'b0;
        chk("frame_full_after_load", m_full, 0);

        // last without valid neither frames nor finalises
        drive(0, 0, 0, 1'b0, 1'b1);
        tick();
        chk("unq_last_out_last", m_olast, 0);
        chk("unq_last_full", m_full, 0);

        // single-beat frame that overflows the output width
        drive(0, 32767, 32767, 1'b1, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0, 1'b0);
        m_load = 1'b1;
`ifdef INTEGER_MAC_PE_SAT_EN
        q_m.push_back(pk(1'b1, 32767));
`else
        q_m.push_back(pk(1'b0, 1));
`endif
        tick();
        m_load = 1'b0;

        // overwrite of an unloaded result sets the sticky lost flag
        drive(0, 1, 10, 1'b1, 1'b1);
        tick();
        drive(0, 2, 2, 1'b1, 1'b1);
        tick();
        chk("ovw_lost", m_lost, 1);
        chk("ovw_full", m_full, 1);
        drive(0, 0, 0, 1'b0, 1'b0);
        m_load = 1'b1; q_m.push_back(pk(1'b0, 4));
        tick();
        m_load = 1'b0;
        chk("ovw_lost_sticky", m_lost, 1);
        chk("ovw_full_cleared", m_full, 0);

        // reset pulse mid-frame discards the partial sum and clears lost
        drive(0, 5, 5, 1'b1, 1'b0);
        tick();
        drive(0, 0, 0, 1'b0, 1'b0);
        rstn = 1'b0;
        #2;
        chk("midrst_lost", m_lost, 0);
        chk("midrst_out_valid", m_ovalid, 0);
        rstn = 1'b1;
        drive(0, 2, 2, 1'b1, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0, 1'b0);
        m_load = 1'b1; q_m.push_back(pk(1'b0, 4));
        tick();
        m_load = 1'b0;
        chk("midrst_lost_after", m_lost, 0);

        // finalise and load in the same cycle: old result drains, new one held, no loss
        drive(0, 1, 7, 1'b1, 1'b1);
        tick();
        drive(0, 2, 3, 1'b1, 1'b1);
        m_load = 1'b1; q_m.push_back(pk(1'b0, 7));
        tick();
        drive(0, 0, 0, 1'b0, 1'b0);
        m_load = 1'b0;
        chk("same_cycle_full", m_full, 1);
        chk("same_cycle_lost", m_lost, 0);
        m_load = 1'b1; q_m.push_back(pk(1'b0, 6));
        tick();
        m_load = 1'b0;
        chk("same_cycle_full_after", m_full, 0);

        // two-PE chain: downstream 10, upstream 20, load then shift once
        drive(0, 2, 5, 1'b1, 1'b1);
        drive(1, 4, 5, 1'b1, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0, 1'b0);
        drive(1, 0, 0, 1'b0, 1'b0);
        m_load = 1'b1; u_load = 1'b1; q_m.push_back(pk(1'b0, 10));
        tick();
        m_load = 1'b0; u_load = 1'b0;
        m_shift = 1'b1; u_shift = 1'b1; q_m.push_back(pk(1'b0, 20));
        tick();
        m_shift = 1'b0; u_shift = 1'b0;
        chk("chain_valid", m_dvalid, 1);
        chk("chain_up_valid", u_dvalid, 0);

        // SHIFT=8 instance: floor rounding of negative values
        drive(2, -1, 1, 1'b1, 1'b1);
        tick();
        drive(2, 0, 0, 1'b0, 1'b0);
        s_load = 1'b1; q_s.push_back(pk(1'b0, -1));
        tick();
        s_load = 1'b0;
        drive(2, 256, 3, 1'b1, 1'b1);
        tick();
        drive(2, 0, 0, 1'b0, 1'b0);
        s_load = 1'b1; q_s.push_back(pk(1'b0, 3));
        tick();
        s_load = 1'b0;
        drive(2, -100, 3, 1'b1, 1'b1);
        tick();
        drive(2, 0, 0, 1'b0, 1'b0);
        s_load = 1'b1; q_s.push_back(pk(1'b0, -2));
        tick();
        s_load = 1'b0;

        repeat (3) tick();
        chk("main_queue_drained", q_m.size(), 0);
        chk("sh8_queue_drained", q_s.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/integer_mac_pe_os.md
Name: integer_mac_pe_os

Overview:
Parametrised output-stationary integer MAC processing element for the systolic array; next generation of the fixed 16-bit PE.
- Forwards row and column operands with valid/last framing.
- Accumulates a framed dot product at full precision, then shifts and narrows the result into a holding register.
- Results leave through a load/shift drain chain, so the array can compute the next tile while the current one drains.

Parameters:
- DATA_W, 16: signed operand width for in_row and in_col.
- ACC_W, 40: signed accumulator width; must be at least 2*DATA_W.
- OUT_W, 16: signed result width on the drain chain.
- SHIFT, 0: arithmetic right shift applied to the accumulator before narrowing; range 0..ACC_W-OUT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_row  in  DATA_W  signed row operand.
- in_col  in  DATA_W  signed column operand.
- in_valid  in  1  operand pair valid.
- in_last  in  1  last pair of the frame; qualified by in_valid.
- out_row  out  DATA_W  registered copy of in_row.
- out_col  out  DATA_W  registered copy of in_col.
- out_valid  out  1  registered copy of in_valid.
- out_last  out  1  registered in_valid&in_last.
- drain_load  in  1  copy the held result into the drain register.
- drain_shift  in  1  shift the drain chain by one PE.
- drain_in  in  OUT_W  drain data from the upstream PE.
- drain_in_valid  in  1  upstream drain register valid.
- drain_out  out  OUT_W  drain register.
- drain_out_valid  out  1  drain register valid.
- drain_out_sat  out  1  saturation flag carried with drain_out.
- result_full  out  1  held result not yet loaded.
- result_lost  out  1  sticky; a held result was overwritten.

Behaviour:
- Reset: every register and every output goes to 0 immediately, including mid-frame; the FSM returns to IDLE.
- Forwarding: one-cycle registered pass-through every cycle, independent of in_valid; the PE never stalls.
- Product: in_row*in_col at full 2*DATA_W precision, sign-extended to ACC_W.
- Accumulator FSM states:
  - IDLE: on in_valid, acc <= product and go to RUN.
  - RUN: on in_valid, acc <= acc + product.
  - On in_valid&in_last in either state: go to IDLE. A frame can therefore be a single beat.
- Accumulator overflow wraps modulo 2^ACC_W; no flag is raised.
- Finalise, on the cycle in_valid&in_last is sampled:
  - result <= narrow(acc_next >>> SHIFT), with floor rounding; sat_flag is stored alongside.
  - result_full <= 1, visible one cycle after the last beat.
- drain_load with result_full set:
  - drain_out <= result, drain_out_sat <= sat_flag, drain_out_valid <= 1, result_full <= 0.
- drain_load with result_full clear:
  - drain_out_valid <= 0.
- drain_shift (when drain_load is not asserted):
  - drain_out <= drain_in, drain_out_valid <= drain_in_valid.
  - drain_out_sat is cleared because upstream flags are not chained.
- drain_load has priority over drain_shift when both are asserted.
- Finalise and drain_load in the same cycle: the load takes the old result and the new result is held with result_full staying 1. result_lost is not set.
- Finalise while result_full=1 and no drain_load: the new result overwrites the held one and result_lost sets. result_lost clears only on reset.

Optional Feature:
INTEGER_MAC_PE_SAT_EN
- Defined: narrow() saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and sat_flag=1 when clamping occurred.
- Undefined: narrow() truncates to the low OUT_W bits, and sat_flag and drain_out_sat are tied to 0.

Decomposition:
- Package integer_mac_pkg holds:
  - default width constants;
  - the FSM state typedef (IDLE/RUN);
  - a width-check function used in an elaboration assertion that ACC_W>=2*DATA_W and SHIFT<=ACC_W-OUT_W.
- Sub-module integer_mac_narrow: combinational shift plus saturate/truncate, parametrised by ACC_W, OUT_W and SHIFT, and carrying the macro-dependent logic.

Test Plan:
All scenarios use DATA_W=16, ACC_W=40, OUT_W=16, SHIFT=0 unless stated.
1. Reset and forwarding: rstn=0 -> all outputs 0. Release rstn, drive (3,4) with valid -> next cycle out_row=3, out_col=4, out_valid=1, result_full=0.
2. Frame: (3,4), (-5,6), (7,-2) with last on the third beat -> result_full=1 one cycle after the last beat. drain_load -> drain_out=-32, drain_out_valid=1, result_full=0.
3. Saturation: single beat (32767,32767) with last.
   - With the macro: drain_out=32767, drain_out_sat=1.
   - Without the macro: drain_out=1 (0x3FFF0001 truncated), drain_out_sat=0.
4. SHIFT=8 instance:
   - (-1,1) with last -> drain_out=-1.
   - (256,3) with last -> drain_out=3.
5. Two-PE chain: results 10 (downstream) and 20 (upstream); drain_load, then one drain_shift -> downstream drain_out goes 10 then 20, and drain_out_valid stays 1.
6. Hazards:
   - Second frame finalises while result_full=1 with no load -> result_lost=1 and the second result is held.
   - rstn pulse mid-frame after beat (5,5), then frame (2,2) with last -> result=4 and result_lost=0.
